uart_transmit: RTL and testbench
================================

// Module: uart_transmit
// PURPOSE
//  Serialises bytes onto a UART line: 8 data bits, LSB first, 1 start bit, STOP_BITS stop bits.
//  Companion to uart_receive; drives the line that uart_receive samples on its uart_tx input.
//  Has a one-byte holding register so the next byte can be queued during a frame.
//  Back-to-back frames therefore leave no idle gap. Sits between the host logic and the FPGA TX pin.
// PARAMETERS
//  CLKS_PER_BIT  7   clk cycles per bit; must match uart_receive; legal range >= 2
//  STOP_BITS     1   number of stop bits; legal values 1 or 2
//  PARITY_ODD    0   parity sense when UART_PARITY_EN is defined: 0 = even, 1 = odd
// PORTS
//  clk           in   1  system clock; all logic on its rising edge
//  rst           in   1  synchronous, active-high reset
//  data          in   8  byte to send; sampled only on an accepted send
//  send          in   1  request; accepted on a rising edge where send && ready
//  ready         out  1  holding register empty; a send is accepted this cycle
//  transmitting  out  1  high while a frame (start..last stop) is on the line
//  done          out  1  one-cycle pulse in the cycle after the last stop bit completes
//  uart_tx       out  1  serial line, registered output, idles high
// BEHAVIOUR
//  Reset values: uart_tx=1, ready=1, transmitting=0, done=0.
//   Reset also empties the shifter and the holding register and puts the FSM in IDLE.
//  FSM states: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP(STOP_BITS) -> IDLE or START.
//  Bit timer: counts 0..CLKS_PER_BIT-1; each line level is held exactly CLKS_PER_BIT cycles.
//  Accepted send in IDLE at edge N: byte goes straight to the shifter.
//   At edge N, uart_tx=0 and transmitting=1; ready remains 1.
//  Accepted send while transmitting: byte goes to the holding register; ready=0 at the next edge.
//  send while ready=0: ignored; data is not sampled and no error is flagged.
//  DATA phase: bit i = data[i], i = 0..7, LSB first.
//  End of the last stop bit:
//   - Holding register full: load it into the shifter, go to START with uart_tx=0 on the same edge
//     (zero idle cycles), set ready=1, pulse done.
//   - Holding register empty: go to IDLE, transmitting=0, pulse done.
//  Frame length = (1+8+STOP_BITS[+1 parity]) * CLKS_PER_BIT cycles; 70 for the default 8N1.
//  rst mid-frame: frame is abandoned, uart_tx=1 at the next edge, held byte is discarded,
//   and done is not pulsed.
//  send coincident with rst: rst wins and the byte is dropped.
// CONFIGURATION
//  UART_PARITY_EN defined: a parity bit is inserted after bit 7.
//   Its value is ^data when PARITY_ODD=0 and ~^data when PARITY_ODD=1.
//   Frame length is 11 bits at the default settings.
//  UART_PARITY_EN undefined: no parity state, PARITY_ODD is ignored, frame is 10 bits.
// STRUCTURE
//  Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP).
//   It also holds DATA_BITS=8 and the CLKS_PER_BIT default, shared with uart_receive.
//  Sub-module uart_bit_timer: counter with load/clear and a terminal-count pulse.
//   The same unit is reusable in uart_receive.
//  Top level holds the FSM, shifter, holding register, bit index (0..7) and stop-bit counter.
// TESTING
//  1 Reset, then send 0x55 at cycle 0.
//    -> uart_tx: 0 for 7 cycles, then 1,0,1,0,1,0,1,0 at 7 cycles each, then 1.
//    -> done pulses at cycle 70; transmitting falls the same cycle.
//  2 send 0xA3, then send 0x0F at cycle 20.
//    -> ready=0 from cycle 21; second start bit begins at cycle 70 with no idle gap.
//    -> done pulses at cycle 70 and at cycle 140.
//  3 send 0xFF at cycle 0, send again at cycles 20 and 30.
//    -> the cycle-30 send is ignored (ready=0); exactly two frames are sent, 0xFF then the cycle-20 byte.
//  4 rst at cycle 35 of a 0x00 frame.
//    -> uart_tx=1 from cycle 36, transmitting=0, ready=1, no done pulse.
//    -> a new send at cycle 40 produces a clean full frame.
//  5 UART_PARITY_EN, PARITY_ODD=0, send 0x07.
//    -> parity bit 1 during cycles 63..69, stop bit 70..76, done at cycle 77.
//  6 Loopback uart_tx into uart_receive with random bytes, STOP_BITS 1 and 2.
//    -> uart_receive data equals each sent byte and new_data fires once per frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period and FSM state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, with clear/load and a terminal-count flag.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 7,
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            tc_c
);

  localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tc_c = en_i && (cnt_q == Last);

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter with one-byte holding register for gap-free back-to-back frames.
// Optional parity bit after bit 7 when UART_PARITY_EN is defined.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 ready,
  output logic                 transmitting,
  output logic                 done,
  output logic                 uart_tx
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept_c, bit_end_c, timer_en_c, load_c;
  logic [DATA_BITS-1:0] load_byte_c;

`ifdef UART_PARITY_EN
  logic par_q, par_d;
`else
  // PARITY_ODD has no effect without a parity bit
  localparam bit unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign accept_c   = send && ready_q;
  assign timer_en_c = (state_q != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (timer_en_c),
    .clear_i   (load_c),
    .load_i    (1'b0),
    .load_val_i({CntW{1'b0}}),
    .tc_c      (bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef UART_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    tx_d        = tx_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_c      = 1'b0;
    load_byte_c = data;
`ifdef UART_PARITY_EN
    par_d       = par_q;
`endif

    // A send accepted mid-frame is parked in the holding register
    if (accept_c && (state_q != IDLE)) begin
      hold_d      = data;
      hold_full_d = 1'b1;
      ready_d     = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          load_c  = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state_d    = PARITY;
            tx_d       = par_q;
`else
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            // Chain straight into the next start bit when a byte is waiting or arriving now
            if (hold_full_q || accept_c) begin
              load_c      = 1'b1;
              load_byte_c = hold_full_q ? hold_q : data;
              hold_full_d = 1'b0;
              ready_d     = 1'b1;
              state_d     = START;
              tx_d        = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      shift_d = load_byte_c;
`ifdef UART_PARITY_EN
      par_d   = (^load_byte_c) ^ 1'(PARITY_ODD);
`endif
    end
  end

  assign ready        = ready_q;
  assign transmitting = busy_q;
  assign done         = done_q;
  assign uart_tx      = tx_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit: cycle-exact frame checks plus a line-decoding scoreboard.
module tb_uart_transmit;

  localparam int CPB1 = 7;
  localparam int CPB2 = 4;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL1 = (9 + 1 + PB) * CPB1;
  localparam int NB1 = 9 + 1 + PB;
  localparam int NB2 = 9 + 2 + PB;
  localparam int NTV = 8;
  localparam int NLB = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data, data2;
  logic       send, send2;
  logic       ready, ready2, transmitting, busy2, done, done2, uart_tx, tx2;

  int total = 0;
  int bad = 0;
  int frames [2] = '{0, 0};
  int done2_cnt = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  typedef struct {
    logic [7:0] d;
    int         done_at;
  } vec_t;
  vec_t tv [NTV];

  always #5 clk = ~clk;

  uart_transmit #(.CLKS_PER_BIT(CPB1), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .data(data), .send(send), .ready(ready),
    .transmitting(transmitting), .done(done), .uart_tx(uart_tx)
  );

  uart_transmit #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst(rst), .data(data2), .send(send2), .ready(ready2),
    .transmitting(busy2), .done(done2), .uart_tx(tx2)
  );

  always @(negedge clk) if (done2 === 1'b1) done2_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Line level of frame slot k: start, 8 data bits LSB first, even parity if enabled, stop bits
  function automatic logic line_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (PB == 1 && k == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic logic line_of(input int sel);
    return (sel != 0) ? tx2 : uart_tx;
  endfunction

  // Decodes frames off the line at mid-bit and compares against the expected-byte queue
  task automatic rx_mon(input int sel);
    int cpb, nbits, w;
    logic [11:0] fr;
    logic [7:0] b, e;
    logic ab, stops_ok;
    cpb   = (sel != 0) ? CPB2 : CPB1;
    nbits = (sel != 0) ? NB2 : NB1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || line_of(sel) !== 1'b0) continue;
      ab = 1'b0;
      fr = '1;
      for (int k = 0; k < nbits; k++) begin
        w = (k == 0) ? cpb / 2 : cpb;
        for (int j = 0; j < w; j++) begin
          @(negedge clk);
          if (rst !== 1'b0) ab = 1'b1;
        end
        fr[k] = line_of(sel);
        if (ab) break;
      end
      if (ab) continue;
      frames[sel]++;
      b = fr[8:1];
      stops_ok = 1'b1;
      for (int s = 9 + PB; s < nbits; s++) if (fr[s] !== 1'b1) stops_ok = 1'b0;
      chk($sformatf("mon%0d_start", sel), 32'(fr[0]), 32'd0);
      chk($sformatf("mon%0d_stop", sel), 32'(stops_ok), 32'd1);
      if (PB == 1) chk($sformatf("mon%0d_parity", sel), 32'(fr[9]), 32'(^b));
      if ((sel != 0 ? sb1.size() : sb0.size()) == 0) begin
        chk($sformatf("mon%0d_unexpected_frame", sel), 32'(b), 32'h1ff);
      end else begin
        e = (sel != 0) ? sb1.pop_front() : sb0.pop_front();
        chk($sformatf("mon%0d_byte", sel), 32'(b), 32'(e));
      end
    end
  endtask

  initial rx_mon(0);
  initial rx_mon(1);

  // One frame from idle: line checked every cycle, done/transmitting at the frame boundary
  task automatic single_frame(input logic [7:0] b, input int done_at);
    data = b;
    send = 1'b1;
    sb0.push_back(b);
    for (int c = 0; c <= done_at + 1; c++) begin
      tick();
      send = 1'b0;
      if (c < done_at) begin
        chk($sformatf("tx_%0h@%0d", b, c), 32'(uart_tx), 32'(line_bit(b, c / CPB1)));
        chk($sformatf("busy_%0h@%0d", b, c), 32'(transmitting), 32'd1);
        chk($sformatf("done_%0h@%0d", b, c), 32'(done), 32'd0);
        if (c == 0) chk($sformatf("ready_%0h@0", b), 32'(ready), 32'd1);
      end else if (c == done_at) begin
        chk($sformatf("done_end_%0h", b), 32'(done), 32'd1);
        chk($sformatf("busy_end_%0h", b), 32'(transmitting), 32'd0);
        chk($sformatf("tx_end_%0h", b), 32'(uart_tx), 32'd1);
        chk($sformatf("ready_end_%0h", b), 32'(ready), 32'd1);
      end else begin
        chk($sformatf("done_after_%0h", b), 32'(done), 32'd0);
      end
    end
  endtask

  // Two queued frames: second byte at cycle 20, optional ignored send at cycle 30
  task automatic two_frames(input logic [7:0] b0, input logic [7:0] b1, input logic extra);
    logic ex;
    for (int c = 0; c <= 2 * FL1 + 8; c++) begin
      if (c == 0) begin data = b0; send = 1'b1; sb0.push_back(b0); end
      if (c == 20) begin data = b1; send = 1'b1; sb0.push_back(b1); end
      if (extra && c == 30) begin data = 8'h11; send = 1'b1; end
      tick();
      send = 1'b0;
      if (c < FL1) ex = line_bit(b0, c / CPB1);
      else if (c < 2 * FL1) ex = line_bit(b1, (c - FL1) / CPB1);
      else ex = 1'b1;
      chk($sformatf("b2b_tx@%0d", c), 32'(uart_tx), 32'(ex));
      chk($sformatf("b2b_done@%0d", c), 32'(done), 32'(c == FL1 || c == 2 * FL1));
      chk($sformatf("b2b_busy@%0d", c), 32'(transmitting), 32'(c < 2 * FL1));
      if (c != 20) chk($sformatf("b2b_ready@%0d", c), 32'(ready), 32'(c < 20 || c >= FL1));
    end
  endtask

  task automatic wait_ready(input int sel);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (((sel != 0) ? ready2 : ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk($sformatf("ready_timeout%0d", sel), 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; data = '0; send2 = 1'b0; data2 = '0;
    tv[0] = '{8'h55, FL1}; tv[1] = '{8'h00, FL1}; tv[2] = '{8'hFF, FL1};
    tv[3] = '{8'h07, FL1}; tv[4] = '{8'h80, FL1}; tv[5] = '{8'h01, FL1};
    tv[6] = '{8'hA3, FL1}; tv[7] = '{8'h3C, FL1};

    tick(); tick();
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(transmitting), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    chk("rst_ready2", 32'(ready2), 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NTV; i++) begin
      single_frame(tv[i].d, tv[i].done_at);
      tick();
    end

    two_frames(8'hA3, 8'h0F, 1'b0);
    two_frames(8'hFF, 8'h5A, 1'b1);

    // Reset in the middle of a 0x00 frame
    data = 8'h00; send = 1'b1; sb0.push_back(8'h00);
    for (int c = 0; c <= 35; c++) begin
      tick();
      send = 1'b0;
      chk($sformatf("abort_tx@%0d", c), 32'(uart_tx), 32'(line_bit(8'h00, c / CPB1)));
    end
    rst = 1'b1;
    sb0.delete();
    tick();
    chk("abort_tx36", 32'(uart_tx), 32'd1);
    chk("abort_busy36", 32'(transmitting), 32'd0);
    chk("abort_ready36", 32'(ready), 32'd1);
    chk("abort_done36", 32'(done), 32'd0);
    rst = 1'b0;
    for (int c = 37; c <= 39; c++) begin
      tick();
      chk($sformatf("abort_idle_tx@%0d", c), 32'(uart_tx), 32'd1);
      chk($sformatf("abort_idle_done@%0d", c), 32'(done), 32'd0);
    end
    single_frame(8'hC5, FL1);

    // send coincident with rst is dropped
    rst = 1'b1; send = 1'b1; data = 8'h99;
    tick();
    rst = 1'b0; send = 1'b0;
    chk("rstsend_busy", 32'(transmitting), 32'd0);
    chk("rstsend_tx", 32'(uart_tx), 32'd1);
    tick(); tick();
    chk("rstsend_busy2", 32'(transmitting), 32'd0);
    chk("rstsend_ready", 32'(ready), 32'd1);

    // Random loopback on both configurations concurrently
    fork
      begin
        logic [7:0] b;
        for (int i = 0; i < NLB; i++) begin
          b = 8'($urandom);
          wait_ready(0);
          data = b; send = 1'b1; sb0.push_back(b);
          tick();
          send = 1'b0;
        end
      end
      begin
        logic [7:0] b;
        for (int i = 0; i < NLB; i++) begin
          b = 8'($urandom);
          wait_ready(1);
          data2 = b; send2 = 1'b1; sb1.push_back(b);
          tick();
          send2 = 1'b0;
        end
      end
    join
    for (int i = 0; i < 3000 && (sb0.size() != 0 || sb1.size() != 0); i++) tick();
    for (int i = 0; i < 4 * CPB1; i++) tick();
    chk("drain0", 32'(sb0.size()), 32'd0);
    chk("drain1", 32'(sb1.size()), 32'd0);
    chk("frames0", 32'(frames[0]), 32'(NTV + 4 + 1 + NLB));
    chk("frames1", 32'(frames[1]), 32'(NLB));
    chk("done2_count", 32'(done2_cnt), 32'(NLB));
    chk("final_busy", 32'(transmitting), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
